fetch_unit: RTL

Instruction-fetch stage of the 5-stage 16-bit pipeline: owns the PC register, drives a variable-latency instruction-memory request/valid handshake, and produces the next IF/ID contents (instruction, PC, valid) each cycle. It is the consumer of the ID stage's stall, redirect and branch-target outputs. It handles:
- memory wait
- stalls
- taken-branch squash, including a redirect that arrives while a memory access is outstanding
- HLT

---
 rtl/wisc_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit_adder.sv | 15 +
 rtl/fetch_unit.sv | 131 +++++++++++++
 4 files changed

// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC pipeline.
// Fetch-stage constants, state encoding and opcode helper.
package wisc_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;
  localparam logic [15:0] PC_RESET  = 16'h0000;
  localparam logic [3:0]  OPC_HLT   = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode(
    input logic [15:0] instr
  );
    return instr[15:12];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/valid handshake.
// Fetch stage is master; the memory is slave.
interface fetch_unit_if;

  logic        Req;
  logic [15:0] Addr;
  logic [15:0] Data;
  logic        Valid;

  modport master (
    output Req,
    output Addr,
    input  Data,
    input  Valid
  );

  modport slave (
    input  Req,
    input  Addr,
    output Data,
    output Valid
  );

endinterface

// File: rtl/fetch_unit_adder.sv
// 16-bit adder/subtractor shared by the pipeline.
// Sub=1 computes A-B via two's complement.
module Adder_16bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Sub,
  output logic [15:0] Sum
);

  logic [15:0] b_op;

  assign b_op = Sub ? ~B : B;
  assign Sum  = A + b_op + {15'b0, Sub};

endmodule

// File: rtl/fetch_unit.sv
// IF stage: PC, variable-latency imem handshake,
// stall buffering, branch squash/redirect and HLT.
module fetch_unit
  import wisc_pkg::*;
#(
  parameter logic [15:0] PC_RESET = wisc_pkg::PC_RESET,
  parameter logic [3:0]  OPC_HLT  = wisc_pkg::OPC_HLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               IF_Stall,
  input  logic               IF_PCDisrupt,
  input  logic [15:0]        IF_PCBranch,
  fetch_unit_if.master       imem,
  output logic               IFID_Wr,
  output logic [15:0]        IFID_Instruction,
  output logic [15:0]        IFID_PC,
  output logic               IFID_Valid,
  output logic               Halted
);

  fetch_state_t state, state_nxt;

  logic [15:0] pc, pc_nxt;
  logic [15:0] redir_pc, redir_nxt;
  logic [15:0] buf_instr, buf_nxt;
  logic [15:0] pc_plus2;

  logic        req;
  logic [15:0] addr;
  logic        ready;
  logic [15:0] data;
  logic        stale_done;

  Adder_16bit u_pc_inc (
    .A   (pc),
    .B   (16'h0002),
    .Sub (1'b0),
    .Sum (pc_plus2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= PC_RESET;
      redir_pc  <= PC_RESET;
      buf_instr <= NOP_INSTR;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      redir_pc  <= redir_nxt;
      buf_instr <= buf_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    redir_nxt        = redir_pc;
    buf_nxt          = buf_instr;
    req              = 1'b0;
    addr             = pc;
    ready            = 1'b0;
    data             = imem.Data;
    IFID_Wr          = 1'b0;
    IFID_Instruction = NOP_INSTR;
    IFID_PC          = pc;
    IFID_Valid       = 1'b0;
    Halted           = 1'b0;

    unique case (state)
      FETCH: begin
        req   = 1'b1;
        ready = imem.Valid;
      end
      HOLD: begin
        ready = 1'b1;
        data  = buf_instr;
      end
      DRAIN: req = 1'b1;
      HALT:  Halted = 1'b1;
      default: ;
    endcase

    // The stale access in DRAIN must finish before PC may move.
    stale_done = (state == DRAIN) && imem.Valid;

    if (rst) begin
      req     = 1'b0;
      addr    = PC_RESET;
      IFID_PC = PC_RESET;
      Halted  = 1'b0;
    end else if (IF_PCDisrupt) begin
      if (req && !imem.Valid) begin
        redir_nxt = IF_PCBranch;
        state_nxt = DRAIN;
      end else begin
        pc_nxt    = IF_PCBranch;
        state_nxt = FETCH;
      end
    end else if (IF_Stall) begin
      if (state == FETCH && imem.Valid) begin
        buf_nxt   = imem.Data;
        state_nxt = HOLD;
      end else if (stale_done) begin
        pc_nxt    = redir_pc;
        state_nxt = FETCH;
      end
    end else if (ready) begin
      IFID_Wr          = 1'b1;
      IFID_Valid       = 1'b1;
      IFID_Instruction = data;
      if (opcode(data) == OPC_HLT) begin
        state_nxt = HALT;
      end else begin
        pc_nxt    = pc_plus2;
        state_nxt = FETCH;
      end
    end else begin
      IFID_Wr = 1'b1;
      if (stale_done) begin
        pc_nxt    = redir_pc;
        state_nxt = FETCH;
      end
    end
  end

  assign imem.Req  = req;
  assign imem.Addr = addr;

endmodule
